fat32_bpb_parser: RTL
=====================

Name: fat32_bpb_parser

Overview:
- Consumes the 512-byte byte stream of the FAT32 volume boot sector (sector 0 of the partition) as delivered by the SD-card sector reader.
- Extracts the BIOS Parameter Block fields: reserved sector count, number of FATs, sectors per FAT, sectors per cluster and root cluster.
- Validates the extracted fields and presents them as stable registered outputs to the root-directory address calculation stage downstream.
- Sits between the SD sector read engine and the root-directory/cluster address logic.

Parameters:
- theSizeofSectors, 512: expected bytes per sector; the BPB BytsPerSec field must equal this value.
- ByteIndexWidth, 10: width of the internal byte counter; must hold the value theSizeofSectors.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- ParseStart  input  1  single-cycle pulse: a new boot-sector read is beginning.
- ReadDataValid  input  1  qualifies ReadData; one byte accepted per cycle while high.
- ReadData  input  8  sector byte; offset 0 arrives first.
- ReservedSectors  output  16  BPB RsvdSecCnt (offsets 14–15, little-endian).
- NumberOfFAT  output  9  BPB NumFATs (offset 16), zero-extended.
- theLengthOfFAT  output  32  BPB FATSz32 (offsets 36–39).
- SectorsPerCluster  output  8  BPB SecPerClus (offset 13).
- RootCluster  output  32  BPB RootClus (offsets 44–47).
- BpbValid  output  1  level; all field outputs hold a validated BPB.
- BpbError  output  1  level; the last parse failed validation.
- ErrorCode  output  3  cause of the failure; 0 when there is no error.
- ParseBusy  output  1  high in the RECEIVE and CHECK states.

Behaviour:
- Reset: every output is 0, the state is IDLE, the byte counter is 0, and all shadow registers are 0.
- States:
  - IDLE, DONE, ERROR: ParseStart moves to RECEIVE.
  - RECEIVE: after byte index 511 is accepted, moves to CHECK.
  - CHECK: always lasts exactly one cycle, then moves to DONE or ERROR.
- ParseStart in any state, including RECEIVE and CHECK, aborts any parse in progress. It then:
  - clears the byte counter;
  - clears BpbValid, BpbError and ErrorCode;
  - enters RECEIVE on the next edge.
- ParseStart has priority over ReadDataValid in the same cycle; that byte is discarded.
- Byte acceptance in RECEIVE:
  - Each cycle with ReadDataValid high writes ReadData into shadow registers according to the byte counter, then increments the counter.
  - Offsets of interest: 11–12 BytsPerSec, 13, 14–15, 16, 36–39, 44–47, 510 and 511 (signature).
  - Multi-byte fields are little-endian: the byte at the lowest offset goes into bits [7:0].
  - All other offsets are counted but not stored.
  - Gaps in ReadDataValid are allowed and have no length limit.
- ReadDataValid outside RECEIVE is ignored. Bytes beyond 512 are never accepted.
- CHECK evaluates the following tests in priority order, and the first failing test sets ErrorCode:
  - 1: signature is not 0x55 at offset 510 and 0xAA at offset 511.
  - 2: BytsPerSec ≠ theSizeofSectors.
  - 3: NumFATs = 0.
  - 4: SecPerClus is 0 or not a power of two.
  - 5: FATSz32 = 0.
- CHECK pass:
  - On the CHECK edge, the shadow registers are copied to the field outputs and BpbValid is set.
  - Latency: BpbValid is high one cycle after the edge that accepted byte 511.
- CHECK fail:
  - BpbError and ErrorCode are set.
  - The field outputs keep their previous values, but BpbValid stays 0; consumers must qualify the fields with BpbValid.
- Holding: the field outputs change only at a CHECK pass or at reset. BpbValid, BpbError and ErrorCode hold until the next ParseStart or reset.
- Reset mid-parse: the next edge returns everything to the reset values; the partial sector is discarded.

Test Plan:
- Standard FAT32 sector (BytsPerSec 0x0200, SecPerClus 8, RsvdSecCnt 0x0020, NumFATs 2, FATSz32 0x000003C1, RootClus 2, 0x55/0xAA) streamed continuously -> one cycle after byte 511: BpbValid=1, ReservedSectors=0x0020, NumberOfFAT=2, theLengthOfFAT=0x3C1, SectorsPerCluster=8, RootCluster=2, ErrorCode=0.
- The same sector with random ReadDataValid gaps of 0–5 cycles -> identical outputs; ParseBusy stays high throughout the stream.
- Offset 511 = 0x00 -> BpbError=1, ErrorCode=1, BpbValid=0; the fields retain the values from the previous good parse.
- SecPerClus=6 with NumFATs=0 -> ErrorCode=3, because the NumFATs test has priority over the SecPerClus test.
- ParseStart asserted at byte 200 of a corrupted stream, followed by a full good sector -> BpbValid=1 with the good-sector values. The byte presented with the restarting ParseStart is discarded.
- sys_rst asserted at byte 300 -> all outputs 0 on the next edge. A subsequent ParseStart plus a good sector -> BpbValid=1. Extra bytes with ReadDataValid after byte 511 -> no change.

Source files
------------

// File: rtl/fat32_bpb_parser.sv
// ----------------------------------------------------------------------------
// fat32_bpb_parser
//
// Purpose:
//   Watches the 512-byte FAT32 volume boot sector as it streams in from the
//   SD sector reader. It captures the BIOS Parameter Block fields that the
//   root-directory address stage needs, then validates them. After a good
//   parse it presents the fields as stable registered outputs.
//
// Ports:
//   sys_clk           system clock, all logic on the rising edge
//   sys_rst           synchronous, active-high reset
//   ParseStart        single-cycle pulse, a new boot-sector read begins
//                     (aborts any parse in progress)
//   ReadDataValid     qualifies ReadData, one byte accepted per cycle
//   ReadData          sector byte, offset 0 first
//   ReservedSectors   RsvdSecCnt (offsets 14-15)
//   NumberOfFAT       NumFATs (offset 16), zero-extended to 9 bits
//   theLengthOfFAT    FATSz32 (offsets 36-39)
//   SectorsPerCluster SecPerClus (offset 13)
//   RootCluster       RootClus (offsets 44-47)
//   BpbValid          field outputs hold a validated BPB
//   BpbError          last parse failed validation
//   ErrorCode         failure cause (1 signature, 2 BytsPerSec, 3 NumFATs,
//                     4 SecPerClus, 5 FATSz32), 0 when no error
//   ParseBusy         high while receiving the sector and during the check
// ----------------------------------------------------------------------------
module fat32_bpb_parser #(
  parameter int theSizeofSectors = 512,
  parameter int ByteIndexWidth   = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ParseStart,
  input  logic        ReadDataValid,
  input  logic [7:0]  ReadData,
  output logic [15:0] ReservedSectors,
  output logic [8:0]  NumberOfFAT,
  output logic [31:0] theLengthOfFAT,
  output logic [7:0]  SectorsPerCluster,
  output logic [31:0] RootCluster,
  output logic        BpbValid,
  output logic        BpbError,
  output logic [2:0]  ErrorCode,
  output logic        ParseBusy
);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    CHECK,
    DONE,
    ERROR
  } parse_state_t;

  localparam logic [ByteIndexWidth-1:0] LAST_BYTE = ByteIndexWidth'(theSizeofSectors - 1);

  parse_state_t              state;
  logic [ByteIndexWidth-1:0] byte_count;

  // Shadow copies of the sector fields, filled while the sector streams in.
  // The outputs are updated from them only after validation succeeds.
  logic [15:0] byts_per_sec;
  logic [7:0]  sec_per_clus;
  logic [15:0] rsvd_sec_cnt;
  logic [7:0]  num_fats;
  logic [31:0] fat_sz32;
  logic [31:0] root_clus;
  logic [7:0]  sig_lo;
  logic [7:0]  sig_hi;

  logic [2:0]  check_code;
  logic        spc_pow2;

  // A power of two has exactly one bit set, so clearing its lowest set bit
  // leaves zero.
  assign spc_pow2 = (sec_per_clus != 8'd0) &&
                    ((sec_per_clus & (sec_per_clus - 8'd1)) == 8'd0);

  // Validation of the captured fields. The tests are ordered so that the
  // first failing test determines the reported cause.
  always_comb begin
    check_code = 3'd0;
    if (sig_lo != 8'h55 || sig_hi != 8'hAA)
      check_code = 3'd1;
    else if (byts_per_sec != 16'(theSizeofSectors))
      check_code = 3'd2;
    else if (num_fats == 8'd0)
      check_code = 3'd3;
    else if (!spc_pow2)
      check_code = 3'd4;
    else if (fat_sz32 == 32'd0)
      check_code = 3'd5;
  end

  // Parser FSM with registered outputs. ParseStart outranks everything
  // except reset, so a byte presented in the same cycle as ParseStart is
  // dropped. Bytes arriving outside RECEIVE are ignored.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state             <= IDLE;
      byte_count        <= '0;
      byts_per_sec      <= '0;
      sec_per_clus      <= '0;
      rsvd_sec_cnt      <= '0;
      num_fats          <= '0;
      fat_sz32          <= '0;
      root_clus         <= '0;
      sig_lo            <= '0;
      sig_hi            <= '0;
      ReservedSectors   <= '0;
      NumberOfFAT       <= '0;
      theLengthOfFAT    <= '0;
      SectorsPerCluster <= '0;
      RootCluster       <= '0;
      BpbValid          <= 1'b0;
      BpbError          <= 1'b0;
      ErrorCode         <= '0;
      ParseBusy         <= 1'b0;
    end else if (ParseStart) begin
      state      <= RECEIVE;
      byte_count <= '0;
      BpbValid   <= 1'b0;
      BpbError   <= 1'b0;
      ErrorCode  <= '0;
      ParseBusy  <= 1'b1;
    end else begin
      case (state)
        RECEIVE: begin
          if (ReadDataValid) begin
            case (int'(byte_count))
              11:  byts_per_sec[7:0]   <= ReadData;
              12:  byts_per_sec[15:8]  <= ReadData;
              13:  sec_per_clus        <= ReadData;
              14:  rsvd_sec_cnt[7:0]   <= ReadData;
              15:  rsvd_sec_cnt[15:8]  <= ReadData;
              16:  num_fats            <= ReadData;
              36:  fat_sz32[7:0]       <= ReadData;
              37:  fat_sz32[15:8]      <= ReadData;
              38:  fat_sz32[23:16]     <= ReadData;
              39:  fat_sz32[31:24]     <= ReadData;
              44:  root_clus[7:0]      <= ReadData;
              45:  root_clus[15:8]     <= ReadData;
              46:  root_clus[23:16]    <= ReadData;
              47:  root_clus[31:24]    <= ReadData;
              510: sig_lo              <= ReadData;
              511: sig_hi              <= ReadData;
              default: ;
            endcase
            byte_count <= byte_count + 1'b1;
            if (byte_count == LAST_BYTE)
              state <= CHECK;
          end
        end

        CHECK: begin
          ParseBusy <= 1'b0;
          if (check_code == 3'd0) begin
            ReservedSectors   <= rsvd_sec_cnt;
            NumberOfFAT       <= {1'b0, num_fats};
            theLengthOfFAT    <= fat_sz32;
            SectorsPerCluster <= sec_per_clus;
            RootCluster       <= root_clus;
            BpbValid          <= 1'b1;
            state             <= DONE;
          end else begin
            BpbError  <= 1'b1;
            ErrorCode <= check_code;
            state     <= ERROR;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
